fetch_stage: RTL and testbench

- Instruction fetch stage of the pipelined MIPS datapath.
- Directly upstream of the control unit: owns the PC, requests instructions from the icache, and holds the IF/ID latch whose instr_out drives the control unit's Instr input.
- Handles stall, flush, branch/jump redirect, halt, and keeps a fetch counter.

---
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage with IF/ID latch
//
// Purpose: owns the PC, issues instruction reads to the icache and holds the
// IF/ID latch whose instr_out feeds the control unit. Handles stall, flush,
// branch/jump redirect, halt and counts accepted instructions.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   ihit, iload         icache hit and returned instruction word
//   iREN, iaddr         icache read enable and address (= PC)
//   stall, flush        ID back-pressure, squash of the IF/ID latch
//   redirect(_pc)       taken branch/jump and its target
//   halt                halt decoded from the instruction in IF/ID
//   instr_out, npc_out  latched instruction and its PC+4
//   valid_out           IF/ID latch holds a real instruction
//   halted              fetch stopped after a halt
//   fetch_count         instructions accepted into IF/ID
module fetch_stage #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = 32'h00000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] npc_out,
  output logic              valid_out,
  output logic              halted,
  output logic [WORD_W-1:0] fetch_count
);

  typedef enum logic {FETCH, HALTED} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] npc_q, npc_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] count_q, count_d;
  logic [WORD_W-1:0] pc_plus4;

  // Wraps modulo 2^WORD_W naturally.
  assign pc_plus4 = pc_q + WORD_W'(4);

  assign iaddr       = pc_q;
  assign iREN        = (state_q == FETCH) && !(stall && valid_q) && !redirect && !flush;
  assign halted      = (state_q == HALTED);
  assign instr_out   = instr_q;
  assign npc_out     = npc_q;
  assign valid_out   = valid_q;
  assign fetch_count = count_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    count_d = count_q;
    if (state_q == HALTED) begin
      // Frozen until reset; redirect/flush/ihit have no effect here.
      valid_d = 1'b0;
    end else if (redirect) begin
      // Target is forced word-aligned; redirect wins over stall.
      pc_d    = redirect_pc & ~WORD_W'(3);
      valid_d = 1'b0;
    end else if (flush) begin
      // PC holds so the squashed address is fetched again.
      valid_d = 1'b0;
    end else if (halt && valid_q && !stall) begin
      valid_d = 1'b0;
      state_d = HALTED;
    end else if (stall && valid_q) begin
      // ID is busy with a real instruction: hold everything.
    end else if (iREN && ihit) begin
      instr_d = iload;
      npc_d   = pc_plus4;
      valid_d = 1'b1;
      pc_d    = pc_plus4;
      count_d = count_q + WORD_W'(1);
    end else begin
      // Miss, or stall against an empty latch: insert a bubble.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] iload = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;

  logic        iren0, iren1, valid0, valid1, halted0, halted1;
  logic [31:0] iaddr0, iaddr1, instr0, instr1, npc0, npc1, cnt0, cnt1;

  always #5 CLK = ~CLK;

  fetch_stage #(.WORD_W(32), .PC_INIT(32'h00000000)) dut0 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iren0), .iaddr(iaddr0),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .instr_out(instr0), .npc_out(npc0), .valid_out(valid0),
    .halted(halted0), .fetch_count(cnt0)
  );

  fetch_stage #(.WORD_W(32), .PC_INIT(32'hFFFFFFFC)) dut1 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iren1), .iaddr(iaddr1),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .instr_out(instr1), .npc_out(npc1), .valid_out(valid1),
    .halted(halted1), .fetch_count(cnt1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural view of the stage.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] count;
    logic        valid;
    logic        stopped;
  } mstate_t;

  mstate_t m0, m1;
  bit      known = 0;

  function automatic logic model_iren(input mstate_t s);
    return !s.stopped && !(stall && s.valid) && !redirect && !flush;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic [31:0] init);
    mstate_t n = s;
    if (RST) begin
      n = '0;
      n.pc = init;
    end else if (s.stopped) begin
      n.valid = 1'b0;
    end else if (redirect) begin
      n.pc = (redirect_pc / 4) * 4;
      n.valid = 1'b0;
    end else if (flush) begin
      n.valid = 1'b0;
    end else if (halt && s.valid && !stall) begin
      n.valid = 1'b0;
      n.stopped = 1'b1;
    end else if (stall && s.valid) begin
      n = s;
    end else if (ihit) begin
      n.instr = iload;
      n.npc = s.pc + 32'd4;
      n.pc = s.pc + 32'd4;
      n.valid = 1'b1;
      n.count = s.count + 32'd1;
    end else begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  task automatic compare_model();
    chk("m0_iaddr", iaddr0, m0.pc);
    chk("m0_instr", instr0, m0.instr);
    chk("m0_npc", npc0, m0.npc);
    chk("m0_count", cnt0, m0.count);
    chk("m0_valid", 32'(valid0), 32'(m0.valid));
    chk("m0_halted", 32'(halted0), 32'(m0.stopped));
    chk("m1_iaddr", iaddr1, m1.pc);
    chk("m1_instr", instr1, m1.instr);
    chk("m1_npc", npc1, m1.npc);
    chk("m1_count", cnt1, m1.count);
    chk("m1_valid", 32'(valid1), 32'(m1.valid));
    chk("m1_halted", 32'(halted1), 32'(m1.stopped));
  endtask

  // One clock: drive, check iREN before the edge, advance the model, check after.
  task automatic cycle(input logic r, input logic ih, input logic [31:0] il,
                       input logic st, input logic fl, input logic rd,
                       input logic [31:0] rp, input logic h, output logic iren_seen);
    RST = r; ihit = ih; iload = il; stall = st; flush = fl;
    redirect = rd; redirect_pc = rp; halt = h;
    #1;
    iren_seen = iren0;
    if (known) begin
      chk("m0_iREN", 32'(iren0), 32'(model_iren(m0)));
      chk("m1_iREN", 32'(iren1), 32'(model_iren(m1)));
    end
    @(posedge CLK);
    m0 = model_step(m0, 32'h00000000);
    m1 = model_step(m1, 32'hFFFFFFFC);
    if (r) known = 1;
    #1;
    if (known) compare_model();
  endtask

  typedef struct {
    logic        rst, ih;
    logic [31:0] il;
    logic        st, fl, rd;
    logic [31:0] rp;
    logic        h;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic        e_valid;
    logic [31:0] e_instr, e_npc, e_cnt;
    logic        e_halted;
  } vec_t;

  function automatic vec_t mk(input logic rst, ih, input logic [31:0] il,
                              input logic st, fl, rd, input logic [31:0] rp, input logic h,
                              input logic e_iren, input logic [31:0] e_iaddr, input logic e_valid,
                              input logic [31:0] e_instr, e_npc, e_cnt, input logic e_halted);
    vec_t v;
    v.rst = rst; v.ih = ih; v.il = il; v.st = st; v.fl = fl; v.rd = rd; v.rp = rp; v.h = h;
    v.e_iren = e_iren; v.e_iaddr = e_iaddr; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_npc = e_npc; v.e_cnt = e_cnt; v.e_halted = e_halted;
    return v;
  endfunction

  vec_t tbl[23];

  initial begin
    logic seen;
    // Directed table for dut0 (PC_INIT=0); expectations are values after the edge.
    tbl[0]  = mk(1,0,32'h0,       0,0,0,32'h0,  0, 0, 32'h00,0,32'h0,       32'h00,0,0);
    tbl[1]  = mk(0,1,32'h20010001,0,0,0,32'h0,  0, 1, 32'h04,1,32'h20010001,32'h04,1,0);
    tbl[2]  = mk(0,1,32'h20020002,0,0,0,32'h0,  0, 1, 32'h08,1,32'h20020002,32'h08,2,0);
    tbl[3]  = mk(0,1,32'h8C220000,0,0,0,32'h0,  0, 1, 32'h0C,1,32'h8C220000,32'h0C,3,0);
    tbl[4]  = mk(0,1,32'h11111111,1,0,0,32'h0,  0, 0, 32'h0C,1,32'h8C220000,32'h0C,3,0);
    tbl[5]  = mk(0,1,32'h11111111,1,0,0,32'h0,  0, 0, 32'h0C,1,32'h8C220000,32'h0C,3,0);
    tbl[6]  = mk(0,1,32'h11111111,1,0,0,32'h0,  0, 0, 32'h0C,1,32'h8C220000,32'h0C,3,0);
    tbl[7]  = mk(0,1,32'h22222222,0,0,0,32'h0,  0, 1, 32'h10,1,32'h22222222,32'h10,4,0);
    tbl[8]  = mk(0,1,32'h33333333,1,0,1,32'h43, 0, 0, 32'h40,0,32'h22222222,32'h10,4,0);
    tbl[9]  = mk(0,1,32'h44444444,0,0,0,32'h0,  0, 1, 32'h44,1,32'h44444444,32'h44,5,0);
    tbl[10] = mk(0,0,32'h0,       0,0,1,32'h20, 0, 0, 32'h20,0,32'h44444444,32'h44,5,0);
    tbl[11] = mk(0,1,32'h55555555,0,1,0,32'h0,  0, 0, 32'h20,0,32'h44444444,32'h44,5,0);
    tbl[12] = mk(0,1,32'h66666666,0,0,0,32'h0,  0, 1, 32'h24,1,32'h66666666,32'h24,6,0);
    tbl[13] = mk(0,0,32'h0,       0,0,0,32'h0,  0, 1, 32'h24,0,32'h66666666,32'h24,6,0);
    tbl[14] = mk(0,1,32'hFFFFFFFF,0,0,0,32'h0,  0, 1, 32'h28,1,32'hFFFFFFFF,32'h28,7,0);
    tbl[15] = mk(0,1,32'h77777777,1,0,0,32'h0,  1, 0, 32'h28,1,32'hFFFFFFFF,32'h28,7,0);
    tbl[16] = mk(0,1,32'h77777777,1,0,0,32'h0,  1, 0, 32'h28,1,32'hFFFFFFFF,32'h28,7,0);
    tbl[17] = mk(0,1,32'h77777777,0,0,0,32'h0,  1, 1, 32'h28,0,32'hFFFFFFFF,32'h28,7,1);
    tbl[18] = mk(0,1,32'h88888888,0,0,0,32'h0,  0, 0, 32'h28,0,32'hFFFFFFFF,32'h28,7,1);
    tbl[19] = mk(0,1,32'h88888888,0,0,1,32'h100,0, 0, 32'h28,0,32'hFFFFFFFF,32'h28,7,1);
    tbl[20] = mk(1,1,32'h99999999,0,0,0,32'h0,  0, 0, 32'h00,0,32'h0,       32'h00,0,0);
    tbl[21] = mk(0,1,32'h99999999,0,0,0,32'h0,  1, 1, 32'h04,1,32'h99999999,32'h04,1,0);
    tbl[22] = mk(1,1,32'hAAAAAAAA,0,0,0,32'h0,  0, 0, 32'h00,0,32'h0,       32'h00,0,0);

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].rst, tbl[i].ih, tbl[i].il, tbl[i].st, tbl[i].fl, tbl[i].rd,
            tbl[i].rp, tbl[i].h, seen);
      if (!tbl[i].rst && i != 0) chk($sformatf("v%0d_iREN", i), 32'(seen), 32'(tbl[i].e_iren));
      chk($sformatf("v%0d_iaddr", i), iaddr0, tbl[i].e_iaddr);
      chk($sformatf("v%0d_valid", i), 32'(valid0), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_instr", i), instr0, tbl[i].e_instr);
      chk($sformatf("v%0d_npc", i), npc0, tbl[i].e_npc);
      chk($sformatf("v%0d_count", i), cnt0, tbl[i].e_cnt);
      chk($sformatf("v%0d_halted", i), 32'(halted0), 32'(tbl[i].e_halted));
    end

    // PC_INIT=FFFFFFFC: the first hit wraps PC+4 to zero (dut1 was just reset).
    cycle(0, 1, 32'h12345678, 0, 0, 0, 32'h0, 0, seen);
    chk("wrap_npc", npc1, 32'h00000000);
    chk("wrap_iaddr", iaddr1, 32'h00000000);
    chk("wrap_instr", instr1, 32'h12345678);
    chk("wrap_valid", 32'(valid1), 32'd1);

    // Reset in the same cycle as a hit discards the hit.
    cycle(1, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0, 0, seen);
    chk("rst_hit_valid", 32'(valid1), 32'd0);
    chk("rst_hit_count", cnt1, 32'd0);
    chk("rst_hit_iaddr", iaddr1, 32'hFFFFFFFC);

    // Random stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 99) < 3,
            $urandom_range(0, 3) != 0,
            $urandom,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 8,
            $urandom,
            $urandom_range(0, 99) < 4,
            seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
